// File: rtl/wb_arb_pkg.sv
// Shared writeback-result types and sizing helpers for the writeback arbiter,
// ROB completion path and issue-queue wakeup logic.
package wb_arb_pkg;

  localparam int unsigned INST_ID_BITS = 6;
  localparam int unsigned PRN_BITS     = 6;
  localparam int unsigned MAX_OPERANDS = 3;
  localparam int unsigned DATA_BITS    = 64;

  typedef struct packed {
    logic [INST_ID_BITS-1:0]                  inst_id;
    logic [MAX_OPERANDS-1:0][DATA_BITS-1:0]   data;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    prn;
    logic [MAX_OPERANDS-1:0]                  prn_valid;
  } wb_result_t;

  // Index width for FU_COUNT requesters; never narrower than one bit.
  function automatic int unsigned fuc_bits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_result_arbiter_if.sv
// FU-result / writeback bus bundle. Optional WB_ARB_PERF_EN adds the
// per-FU conflict counters.
interface wb_result_arbiter_if #(
  parameter int unsigned FU_COUNT = 4
);
  import wb_arb_pkg::*;

  localparam int unsigned FUC_BITS = fuc_bits(FU_COUNT);

  logic [FU_COUNT-1:0]                                  fu_valid;
  logic [FU_COUNT-1:0]                                  fu_ready;
  logic [FU_COUNT-1:0][INST_ID_BITS-1:0]                fu_inst_id;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][DATA_BITS-1:0] fu_data;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]  fu_prn;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]                fu_prn_valid;
  logic                                                 wb_hold;
  logic                                                 wb_valid;
  logic [FUC_BITS-1:0]                                  wb_fu_idx;
  logic [INST_ID_BITS-1:0]                              wb_inst_id;
  logic [MAX_OPERANDS-1:0][DATA_BITS-1:0]               wb_data;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                wb_prn;
  logic [MAX_OPERANDS-1:0]                              wb_enable;
`ifdef WB_ARB_PERF_EN
  logic [FU_COUNT-1:0][31:0]                            perf_conflict_cnt;
`endif

  // FU wrappers and commit side
  modport master (
    output fu_valid, fu_inst_id, fu_data, fu_prn, fu_prn_valid, wb_hold,
    input  fu_ready, wb_valid, wb_fu_idx, wb_inst_id, wb_data, wb_prn, wb_enable
`ifdef WB_ARB_PERF_EN
    , input perf_conflict_cnt
`endif
  );

  // Arbiter
  modport slave (
    input  fu_valid, fu_inst_id, fu_data, fu_prn, fu_prn_valid, wb_hold,
    output fu_ready, wb_valid, wb_fu_idx, wb_inst_id, wb_data, wb_prn, wb_enable
`ifdef WB_ARB_PERF_EN
    , output perf_conflict_cnt
`endif
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set req bit scanning ptr, ptr+1, ... mod N.
module rr_picker #(
  parameter int unsigned N = 4,
  parameter int unsigned W = (N < 2) ? 1 : $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx
);

  logic [W-1:0] idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = W'((32'(ptr) + off) % N);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/wb_result_arbiter.sv
// Shares the PRF writeback / wakeup bus among FU_COUNT FUs via one-entry slots
// and a round-robin grant. Optional macro WB_ARB_PERF_EN adds perf_conflict_cnt.
module wb_result_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned FU_COUNT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_result_arbiter_if.slave   bus
);

  localparam int unsigned FUC_BITS = fuc_bits(FU_COUNT);

  logic [FU_COUNT-1:0] slot_v;
  wb_result_t          slot_q [FU_COUNT];
  logic [FUC_BITS-1:0] rr_ptr;
  logic                pick_valid;
  logic [FUC_BITS-1:0] pick_idx;
  logic                grant_en;
  logic [FU_COUNT-1:0] grant;
  logic [FU_COUNT-1:0] ready;

  rr_picker #(.N(FU_COUNT), .W(FUC_BITS)) u_pick (
    .req       (slot_v),
    .ptr       (rr_ptr),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  // A granted slot frees up in the same cycle, so its FU can refill it back-to-back.
  always_comb begin
    grant_en = pick_valid & ~bus.wb_hold;
    grant    = '0;
    if (grant_en) grant[pick_idx] = 1'b1;
    ready        = ~slot_v | grant;
    bus.fu_ready = ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_v         <= '0;
      rr_ptr         <= '0;
      bus.wb_valid   <= 1'b0;
      bus.wb_fu_idx  <= '0;
      bus.wb_inst_id <= '0;
      bus.wb_data    <= '0;
      bus.wb_prn     <= '0;
      bus.wb_enable  <= '0;
      for (int unsigned i = 0; i < FU_COUNT; i++) slot_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < FU_COUNT; i++) begin
        if (bus.fu_valid[i] && ready[i]) begin
          slot_v[i]           <= 1'b1;
          slot_q[i].inst_id   <= bus.fu_inst_id[i];
          slot_q[i].data      <= bus.fu_data[i];
          slot_q[i].prn       <= bus.fu_prn[i];
          slot_q[i].prn_valid <= bus.fu_prn_valid[i];
        end else if (grant[i]) begin
          slot_v[i] <= 1'b0;
        end
      end

      bus.wb_valid <= grant_en;
      if (grant_en) begin
        bus.wb_fu_idx  <= pick_idx;
        bus.wb_inst_id <= slot_q[pick_idx].inst_id;
        bus.wb_data    <= slot_q[pick_idx].data;
        bus.wb_prn     <= slot_q[pick_idx].prn;
        bus.wb_enable  <= slot_q[pick_idx].prn_valid;
        rr_ptr         <= (pick_idx == FUC_BITS'(FU_COUNT - 1)) ? '0
                                                                 : pick_idx + FUC_BITS'(1);
      end else begin
        bus.wb_enable  <= '0;
      end
    end
  end

`ifdef WB_ARB_PERF_EN
  logic [FU_COUNT-1:0][31:0] conflict_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < FU_COUNT; i++) begin
        if (slot_v[i] && !grant[i] && (conflict_cnt[i] != '1))
          conflict_cnt[i] <= conflict_cnt[i] + 32'd1;
      end
    end
  end

  always_comb bus.perf_conflict_cnt = conflict_cnt;
`endif

endmodule

// File: tb/tb_wb_result_arbiter.sv
// Self-checking bench for wb_result_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked against a per-cycle model.
module tb_wb_result_arbiter;
  import wb_arb_pkg::*;

  localparam int unsigned FU = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  wb_result_arbiter_if #(.FU_COUNT(FU)) bus();

  wb_result_arbiter #(.FU_COUNT(FU)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit             m_known = 1'b0;
  bit             m_v [FU];
  wb_result_t     m_slot [FU];
  int unsigned    m_ptr;
  bit             m_wb_valid;
  int unsigned    m_wb_idx;
  wb_result_t     m_wb;
  logic [MAX_OPERANDS-1:0] m_en;
  int             g;
  logic [FU-1:0]  exp_rdy;
`ifdef WB_ARB_PERF_EN
  longint unsigned m_cnt [FU];
`endif

  initial begin
    forever begin
      @(negedge clk);
      g = -1;
      if (!bus.wb_hold)
        for (int unsigned off = 0; off < FU; off++)
          if (g < 0 && m_v[(m_ptr + off) % FU]) g = int'((m_ptr + off) % FU);
      for (int unsigned i = 0; i < FU; i++) exp_rdy[i] = !m_v[i] || (g == int'(i));

      if (m_known) begin
        chk("fu_ready", bus.fu_ready, exp_rdy);
        chk("wb_valid", bus.wb_valid, m_wb_valid);
        chk("wb_enable", bus.wb_enable, m_en);
        chk("wb_inst_id", bus.wb_inst_id, m_wb.inst_id);
        chk("wb_data", bus.wb_data, m_wb.data);
        chk("wb_prn", bus.wb_prn, m_wb.prn);
        if (m_wb_valid) chk("wb_fu_idx", bus.wb_fu_idx, m_wb_idx);
`ifdef WB_ARB_PERF_EN
        for (int unsigned i = 0; i < FU; i++)
          chk("perf_cnt", bus.perf_conflict_cnt[i], m_cnt[i]);
`endif
      end

      if (rst) begin
        m_known    = 1'b1;
        m_ptr      = 0;
        m_wb_valid = 1'b0;
        m_wb_idx   = 0;
        m_wb       = '0;
        m_en       = '0;
        for (int unsigned i = 0; i < FU; i++) begin
          m_v[i] = 1'b0;
`ifdef WB_ARB_PERF_EN
          m_cnt[i] = 0;
`endif
        end
      end else if (m_known) begin
`ifdef WB_ARB_PERF_EN
        for (int unsigned i = 0; i < FU; i++)
          if (m_v[i] && g != int'(i) && m_cnt[i] < 64'hFFFF_FFFF) m_cnt[i]++;
`endif
        if (g >= 0) begin
          m_wb_valid = 1'b1;
          m_wb_idx   = g;
          m_wb       = m_slot[g];
          m_en       = m_slot[g].prn_valid;
          m_ptr      = (g + 1) % FU;
        end else begin
          m_wb_valid = 1'b0;
          m_en       = '0;
        end
        for (int unsigned i = 0; i < FU; i++) begin
          if (bus.fu_valid[i] && exp_rdy[i]) begin
            m_v[i]                = 1'b1;
            m_slot[i].inst_id     = bus.fu_inst_id[i];
            m_slot[i].data        = bus.fu_data[i];
            m_slot[i].prn         = bus.fu_prn[i];
            m_slot[i].prn_valid   = bus.fu_prn_valid[i];
          end else if (g == int'(i)) begin
            m_v[i] = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int unsigned i, input int unsigned inst, input logic [2:0] pv);
    bus.fu_inst_id[i]   = 6'(inst);
    bus.fu_prn_valid[i] = pv;
    for (int unsigned j = 0; j < MAX_OPERANDS; j++) begin
      bus.fu_prn[i][j]  = 6'(inst + j);
      bus.fu_data[i][j] = {32'(i), 32'(inst * 16 + j)};
    end
  endtask

  logic [FU-1:0] stall;

  initial begin
    bus.fu_valid     = '0;
    bus.fu_inst_id   = '0;
    bus.fu_data      = '0;
    bus.fu_prn       = '0;
    bus.fu_prn_valid = '0;
    bus.wb_hold      = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: single FU0 result appears two cycles later
    step();
    set_fu(0, 5, 3'b001);
    bus.fu_prn[0][0] = 6'd12;
    bus.fu_valid     = 4'b0001;
    @(negedge clk); chk("t1_ready0", bus.fu_ready[0], 1'b1);
    step(); bus.fu_valid = '0;
    @(negedge clk); chk("t1_c2_valid", bus.wb_valid, 1'b0);
    step();
    @(negedge clk);
    chk("t1_valid", bus.wb_valid, 1'b1);
    chk("t1_idx", bus.wb_fu_idx, 2'd0);
    chk("t1_enable", bus.wb_enable, 3'b001);
    chk("t1_inst", bus.wb_inst_id, 6'd5);
    chk("t1_prn0", bus.wb_prn[0], 6'd12);

    // 2: all four together from rr_ptr=0
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    for (int unsigned i = 0; i < FU; i++) set_fu(i, 10 + i, 3'b111);
    bus.fu_valid = 4'b1111;
    step(); bus.fu_valid = '0;
    for (int unsigned k = 0; k < FU; k++) begin
      step();
      @(negedge clk);
      chk("t2_valid", bus.wb_valid, 1'b1);
      chk("t2_idx", bus.wb_fu_idx, k);
      chk("t2_inst", bus.wb_inst_id, 10 + k);
    end
    step();
    @(negedge clk); chk("t2_idle", bus.wb_valid, 1'b0);
    // pointer wrapped to 0: FU0 beats FU3
    step();
    set_fu(0, 40, 3'b000); set_fu(3, 43, 3'b100);
    bus.fu_valid = 4'b1001;
    step(); bus.fu_valid = '0;
    step(); @(negedge clk);
    chk("t2w_idx0", bus.wb_fu_idx, 2'd0);
    chk("t2w_noprn_valid", bus.wb_valid, 1'b1);
    chk("t2w_noprn_en", bus.wb_enable, 3'b000);
    step(); @(negedge clk); chk("t2w_idx3", bus.wb_fu_idx, 2'd3);

    // 3: FU2 streams every cycle
    for (int unsigned k = 0; k < 8; k++) begin
      step();
      bus.fu_valid = (k < 6) ? 4'b0100 : 4'b0000;
      set_fu(2, 20 + k, 3'b010);
      @(negedge clk);
      if (k < 6) chk("t3_ready2", bus.fu_ready[2], 1'b1);
      if (k >= 2) begin
        chk("t3_valid", bus.wb_valid, 1'b1);
        chk("t3_idx", bus.wb_fu_idx, 2'd2);
        chk("t3_inst", bus.wb_inst_id, 20 + k - 2);
      end
    end

    // 4: hold with all slots full; resume from saved pointer (3)
    step();
    for (int unsigned i = 0; i < FU; i++) set_fu(i, 30 + i, 3'b011);
    bus.fu_valid = 4'b1111;
    bus.wb_hold  = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("t4_ready", bus.fu_ready, 4'b0000);
      chk("t4_valid", bus.wb_valid, 1'b0);
    end
    step(); bus.wb_hold = 1'b0; bus.fu_valid = '0;
    @(negedge clk); chk("t4_rel_valid", bus.wb_valid, 1'b0);
    for (int unsigned k = 0; k < FU; k++) begin
      step();
      @(negedge clk);
      chk("t4_idx", bus.wb_fu_idx, (3 + k) % FU);
      chk("t4_inst", bus.wb_inst_id, 30 + (3 + k) % FU);
    end

    // 5: reset with three slots full
    step();
    for (int unsigned i = 0; i < 3; i++) set_fu(i, 50 + i, 3'b111);
    bus.fu_valid = 4'b0111; bus.wb_hold = 1'b1;
    step(); bus.fu_valid = '0; rst = 1'b1;
    step(); rst = 1'b0; bus.wb_hold = 1'b0;
    @(negedge clk);
    chk("t5_valid", bus.wb_valid, 1'b0);
    chk("t5_ready", bus.fu_ready, 4'b1111);
    for (int unsigned k = 0; k < 3; k++) begin
      step(); @(negedge clk); chk("t5_nostale", bus.wb_valid, 1'b0);
    end

`ifdef WB_ARB_PERF_EN
    // 6: rr_ptr=3 via a lone FU2 grant, then FU1+FU3 contend
    step(); set_fu(2, 60, 3'b001); bus.fu_valid = 4'b0100;
    step(); bus.fu_valid = '0;
    step();
    set_fu(1, 61, 3'b001); set_fu(3, 63, 3'b001);
    bus.fu_valid = 4'b1010;
    step(); bus.fu_valid = '0;
    step(); @(negedge clk);
    chk("t6_idx3", bus.wb_fu_idx, 2'd3);
    chk("t6_cnt1", bus.perf_conflict_cnt[1], 32'd1);
    step(); @(negedge clk);
    chk("t6_idx1", bus.wb_fu_idx, 2'd1);
    chk("t6_cnt1_after", bus.perf_conflict_cnt[1], 32'd1);
`endif

    // randomized traffic; FUs keep stalled outputs stable
    for (int unsigned n = 0; n < 3000; n++) begin
      @(negedge clk);
      stall = bus.fu_valid & ~bus.fu_ready;
      step();
      rst         = ($urandom_range(0, 99) == 0);
      bus.wb_hold = ($urandom_range(0, 3) == 0);
      for (int unsigned i = 0; i < FU; i++) begin
        if (!stall[i]) begin
          bus.fu_valid[i]     = 1'($urandom_range(0, 1));
          bus.fu_inst_id[i]   = 6'($urandom);
          bus.fu_prn_valid[i] = 3'($urandom);
          for (int unsigned j = 0; j < MAX_OPERANDS; j++) begin
            bus.fu_prn[i][j]  = 6'($urandom);
            bus.fu_data[i][j] = {$urandom, $urandom};
          end
        end
      end
    end

    step();
    rst = 1'b0; bus.wb_hold = 1'b0; bus.fu_valid = '0;
    repeat (8) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
